tl_instruction_decode: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline. It consumes the IF/ID outputs (instruction word, PC+1) and holds the 32x32 register file, written back from WB. It also holds the main control decoder, the sign extender and load-use hazard detection. It registers everything into the ID/EX pipeline register for the execute stage.

---
 rtl/tl_instruction_decode.sv | 158 +++++++++++++++
 tb/tb_tl_instruction_decode.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_instruction_decode.sv
// MIPS instruction-decode stage: register file with WB write-through, main control
// decoder, sign extender, load-use hazard detection and the ID/EX pipeline register.
module tl_instruction_decode #(
    parameter int unsigned len    = 32,
    parameter int unsigned NB_REG = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [len-1:0]    i_instruccion,
    input  logic [len-1:0]    i_adder,
    input  logic              i_flush,
    input  logic              i_reg_write_wb,
    input  logic [NB_REG-1:0] i_write_reg_wb,
    input  logic [len-1:0]    i_write_data_wb,
    input  logic              i_id_ex_mem_read,
    input  logic [NB_REG-1:0] i_id_ex_rt,
    output logic              o_stall,
    output logic [len-1:0]    o_adder,
    output logic [len-1:0]    o_read_data1,
    output logic [len-1:0]    o_read_data2,
    output logic [len-1:0]    o_sign_ext,
    output logic [NB_REG-1:0] o_rs,
    output logic [NB_REG-1:0] o_rt,
    output logic [NB_REG-1:0] o_rd,
    output logic              o_reg_dst,
    output logic              o_alu_src,
    output logic              o_branch,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_mem_to_reg,
    output logic              o_reg_write,
    output logic [1:0]        o_alu_op
);

    localparam int unsigned NREGS = 2 ** NB_REG;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [len-1:0]    r_regs [NREGS];
    logic [5:0]        w_opcode;
    logic [NB_REG-1:0] w_rs, w_rt, w_rd;
    logic              w_wb_en;
    logic [len-1:0]    w_read1, w_read2, w_sign_ext;
    logic              w_reg_dst, w_alu_src, w_branch, w_mem_read;
    logic              w_mem_write, w_mem_to_reg, w_reg_write;
    logic [1:0]        w_alu_op;
    logic              w_bubble;

    assign w_opcode = i_instruccion[len-1 -: 6];
    assign w_rs     = i_instruccion[21 +: NB_REG];
    assign w_rt     = i_instruccion[16 +: NB_REG];
    assign w_rd     = i_instruccion[11 +: NB_REG];
    assign w_wb_en  = i_reg_write_wb && (i_write_reg_wb != '0);

    // Register file: $zero never written; reset wins over a same-edge WB write
    always_ff @(negedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[i_write_reg_wb] <= i_write_data_wb;
        end
    end

    // Write-through so a value retiring this cycle reaches ID/EX directly
    assign w_read1 = (w_rs == '0) ? '0 :
                     (w_wb_en && (i_write_reg_wb == w_rs)) ? i_write_data_wb : r_regs[w_rs];
    assign w_read2 = (w_rt == '0) ? '0 :
                     (w_wb_en && (i_write_reg_wb == w_rt)) ? i_write_data_wb : r_regs[w_rt];

    assign w_sign_ext = {{(len-16){i_instruccion[15]}}, i_instruccion[15:0]};

    // Main control decoder; unknown opcodes decode as NOP
    always_comb begin
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = 2'b00;
        case (w_opcode)
            OP_RTYPE: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = 2'b10;
            end
            OP_LW: begin
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
            end
            OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_branch = 1'b1;
                w_alu_op = 2'b01;
            end
            OP_ADDI: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = 2'b11;
            end
            default: ;
        endcase
    end

    assign o_stall  = i_id_ex_mem_read && (i_id_ex_rt != '0) &&
                      ((i_id_ex_rt == w_rs) || (i_id_ex_rt == w_rt));
    assign w_bubble = o_stall || i_flush;

    // ID/EX register: data always advances, control zeroed on a bubble
    always_ff @(negedge i_clk) begin
        if (!i_rst) begin
            o_adder      <= '0;
            o_read_data1 <= '0;
            o_read_data2 <= '0;
            o_sign_ext   <= '0;
            o_rs         <= '0;
            o_rt         <= '0;
            o_rd         <= '0;
            o_reg_dst    <= 1'b0;
            o_alu_src    <= 1'b0;
            o_branch     <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_reg_write  <= 1'b0;
            o_alu_op     <= 2'b00;
        end else begin
            o_adder      <= i_adder;
            o_read_data1 <= w_read1;
            o_read_data2 <= w_read2;
            o_sign_ext   <= w_sign_ext;
            o_rs         <= w_rs;
            o_rt         <= w_rt;
            o_rd         <= w_rd;
            o_reg_dst    <= w_reg_dst    && !w_bubble;
            o_alu_src    <= w_alu_src    && !w_bubble;
            o_branch     <= w_branch     && !w_bubble;
            o_mem_read   <= w_mem_read   && !w_bubble;
            o_mem_write  <= w_mem_write  && !w_bubble;
            o_mem_to_reg <= w_mem_to_reg && !w_bubble;
            o_reg_write  <= w_reg_write  && !w_bubble;
            o_alu_op     <= w_bubble ? 2'b00 : w_alu_op;
        end
    end

endmodule

// File: tb/tb_tl_instruction_decode.sv
// Self-checking bench for tl_instruction_decode: directed scenarios plus randomized
// traffic against an array-based register model and a control truth table.
module tb_tl_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, adder;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ex_mr;
    logic [4:0]  ex_rt;
    logic        stall;
    logic [31:0] q_adder, q_rd1, q_rd2, q_sext;
    logic [4:0]  q_rs, q_rt, q_rd;
    logic        q_reg_dst, q_alu_src, q_branch, q_mem_read, q_mem_write, q_mem_to_reg, q_reg_write;
    logic [1:0]  q_alu_op;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_regs [32];

    always #5 clk = ~clk;

    tl_instruction_decode #(.len(32), .NB_REG(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_instruccion(instr), .i_adder(adder), .i_flush(flush),
        .i_reg_write_wb(wb_en), .i_write_reg_wb(wb_reg), .i_write_data_wb(wb_data),
        .i_id_ex_mem_read(ex_mr), .i_id_ex_rt(ex_rt), .o_stall(stall),
        .o_adder(q_adder), .o_read_data1(q_rd1), .o_read_data2(q_rd2), .o_sign_ext(q_sext),
        .o_rs(q_rs), .o_rt(q_rt), .o_rd(q_rd),
        .o_reg_dst(q_reg_dst), .o_alu_src(q_alu_src), .o_branch(q_branch),
        .o_mem_read(q_mem_read), .o_mem_write(q_mem_write), .o_mem_to_reg(q_mem_to_reg),
        .o_reg_write(q_reg_write), .o_alu_op(q_alu_op)
    );

    // Control order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch alu_op[1:0]
    function automatic logic [8:0] act_ctrl();
        return {q_reg_dst, q_alu_src, q_mem_to_reg, q_reg_write, q_mem_read,
                q_mem_write, q_branch, q_alu_op};
    endfunction

    function automatic logic [8:0] model_ctrl(input logic [31:0] ins);
        case (ins[31:26])
            6'h00:   return 9'b1_0_0_1_0_0_0_10;
            6'h23:   return 9'b0_1_1_1_1_0_0_00;
            6'h2B:   return 9'b0_1_0_0_0_1_0_00;
            6'h04:   return 9'b0_0_0_0_0_0_1_01;
            6'h08:   return 9'b0_1_0_1_0_0_0_11;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_reg == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic model_stall(input logic [31:0] ins);
        return ex_mr && ex_rt != 5'd0 && (ex_rt == ins[25:21] || ex_rt == ins[20:16]);
    endfunction

    // Apply one negedge and update the architectural register model alongside the DUT
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (wb_en && wb_reg != 5'd0) begin
            m_regs[wb_reg] = wb_data;
        end
        #1;
    endtask

    task automatic idle_inputs();
        @(posedge clk);
        flush = 1'b0; wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        ex_mr = 1'b0; ex_rt = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0; instr = 32'd0; adder = 32'd0;
        idle_inputs();
        tick(); tick();
        rst = 1'b1;
        idle_inputs();
        instr = 32'h00A00820; wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'hAA;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (q_rd1 !== 32'hAA) begin
            failures++; $display("FAIL reset_prewrite got=%h exp=%h", q_rd1, 32'hAA);
        end
        @(posedge clk);
        rst = 1'b0; adder = 32'h1234; instr = 32'h8C22FFFC;
        wb_en = 1'b1; wb_reg = 5'd6; wb_data = 32'h66;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({q_adder, q_rd1, q_rd2, q_sext, q_rs, q_rt, q_rd, act_ctrl()} !== '0) begin
                failures++;
                $display("FAIL reset_outputs edge=%0d adder=%h rd1=%h sext=%h ctrl=%b exp=0",
                         k, q_adder, q_rd1, q_sext, act_ctrl());
            end
        end
        rst = 1'b1;
        idle_inputs();
        instr = 32'h00A60820;
        tick();
        checks++;
        if (q_rd1 !== 32'd0 || q_rd2 !== 32'd0) begin
            failures++; $display("FAIL reset_regs rd1=%h rd2=%h exp=0,0", q_rd1, q_rd2);
        end
    endtask

    task automatic test_writeback_read();
        idle_inputs();
        wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'h12345678; instr = 32'd0;
        tick();
        idle_inputs();
        instr = 32'h00632020; adder = 32'h10;
        tick();
        checks++;
        if (q_rd1 !== 32'h12345678 || q_rd2 !== 32'h12345678 || q_rd !== 5'd4 ||
            act_ctrl() !== 9'b1_0_0_1_0_0_0_10 || q_adder !== 32'h10) begin
            failures++;
            $display("FAIL wb_read rd1=%h rd2=%h rd=%0d ctrl=%b adder=%h exp 12345678/12345678/4/100100010/10",
                     q_rd1, q_rd2, q_rd, act_ctrl(), q_adder);
        end
    endtask

    task automatic test_bypass_zero();
        idle_inputs();
        instr = 32'h20E60005; wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'h55;
        tick();
        checks++;
        if (q_rd1 !== 32'h55) begin
            failures++; $display("FAIL bypass_rs got=%h exp=%h", q_rd1, 32'h55);
        end
        idle_inputs();
        instr = 32'h00000820; wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'hFF;
        tick();
        checks++;
        if (q_rd1 !== 32'd0 || q_rd2 !== 32'd0) begin
            failures++; $display("FAIL zero_same_cycle rd1=%h rd2=%h exp=0", q_rd1, q_rd2);
        end
        idle_inputs();
        tick();
        checks++;
        if (q_rd1 !== 32'd0 || q_rd2 !== 32'd0) begin
            failures++; $display("FAIL zero_later rd1=%h rd2=%h exp=0", q_rd1, q_rd2);
        end
    endtask

    task automatic test_decode_signext();
        logic [31:0] ins_tab [5] = '{32'h8C22FFFC, 32'h10220003, 32'hAC830008, 32'h20E60005, 32'hFC001234};
        logic [8:0]  ctl_tab [5] = '{9'b011110000, 9'b000000101, 9'b010001000, 9'b010100011, 9'b0};
        logic [31:0] sx_tab  [5] = '{32'hFFFFFFFC, 32'h3, 32'h8, 32'h5, 32'h1234};
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            instr = ins_tab[i];
            tick();
            checks++;
            if (act_ctrl() !== ctl_tab[i] || q_sext !== sx_tab[i]) begin
                failures++;
                $display("FAIL decode[%0d] ctrl=%b exp=%b sext=%h exp=%h",
                         i, act_ctrl(), ctl_tab[i], q_sext, sx_tab[i]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [4:0] rt_tab [3] = '{5'd2, 5'd0, 5'd9};
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            instr = 32'h00432820; ex_mr = 1'b1; ex_rt = rt_tab[i];
            #1;
            checks++;
            if (stall !== (i == 0)) begin
                failures++; $display("FAIL stall ex_rt=%0d got=%b exp=%b", rt_tab[i], stall, i == 0);
            end
            tick();
            checks++;
            if (act_ctrl() !== ((i == 0) ? 9'b0 : 9'b100100010) || q_rd !== 5'd5) begin
                failures++;
                $display("FAIL stall_bubble ex_rt=%0d ctrl=%b rd=%0d", rt_tab[i], act_ctrl(), q_rd);
            end
        end
        idle_inputs();
        instr = 32'h00432820; ex_mr = 1'b0; ex_rt = 5'd2;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL stall_release got=%b exp=0", stall);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        instr = 32'h00432820; flush = 1'b1;
        tick();
        checks++;
        if (act_ctrl() !== 9'b0 || q_rd !== 5'd5) begin
            failures++; $display("FAIL flush ctrl=%b rd=%0d exp=0/5", act_ctrl(), q_rd);
        end
        idle_inputs();
        instr = 32'h00432820;
        tick();
        checks++;
        if (act_ctrl() !== 9'b100100010) begin
            failures++; $display("FAIL flush_after ctrl=%b exp=100100010", act_ctrl());
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
        logic [31:0] e_rd1, e_rd2, e_sext, e_adder;
        logic [8:0]  e_ctrl;
        logic [14:0] e_regs;
        logic        e_stall;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            instr = $urandom;
            instr[31:26] = (n % 7 == 6) ? 6'($urandom) : ops[$urandom_range(0, 4)];
            adder   = $urandom;
            flush   = ($urandom_range(0, 7) == 0);
            wb_en   = $urandom_range(0, 1) == 1;
            wb_reg  = ($urandom_range(0, 2) == 0) ? instr[25:21] : 5'($urandom);
            wb_data = $urandom;
            ex_mr   = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       ex_rt = instr[25:21];
                1:       ex_rt = instr[20:16];
                default: ex_rt = 5'($urandom);
            endcase
            #1;
            e_stall = model_stall(instr);
            checks++;
            if (stall !== e_stall) begin
                failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, e_stall);
            end
            e_rd1   = model_read(instr[25:21]);
            e_rd2   = model_read(instr[20:16]);
            e_sext  = 32'($signed(instr[15:0]));
            e_adder = adder;
            e_regs  = instr[25:11];
            e_ctrl  = (e_stall || flush) ? 9'b0 : model_ctrl(instr);
            tick();
            checks++;
            if (q_rd1 !== e_rd1 || q_rd2 !== e_rd2 || q_sext !== e_sext || q_adder !== e_adder ||
                {q_rs, q_rt, q_rd} !== e_regs || act_ctrl() !== e_ctrl) begin
                failures++;
                $display("FAIL rnd_idex n=%0d rd1=%h/%h rd2=%h/%h sext=%h/%h adder=%h/%h regs=%h/%h ctrl=%b/%b",
                         n, q_rd1, e_rd1, q_rd2, e_rd2, q_sext, e_sext, q_adder, e_adder,
                         {q_rs, q_rt, q_rd}, e_regs, act_ctrl(), e_ctrl);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        test_reset();
        test_writeback_read();
        test_bypass_zero();
        test_decode_signext();
        test_load_use();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
